// File: rtl/tiny_host_if.sv
// tiny_host_if: host-side wrapper for the pairing core.
// It takes four 198-bit operands as 7-word bursts, writes them into core RAM,
// runs the core, then streams the six 198-bit results back as 7-word bursts.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     operand word stream (32 bit)
//   out_valid/out_ready/out_data  result word stream (32 bit)
//   busy                  operand burst started, results not yet drained
//   err                   sticky run timeout (constant 0 unless enabled)
//   core_reset            hold to the core, high keeps it silent
//   core_sel/core_w/core_addr/core_data   core RAM access port
//   core_out/core_done    core read data (one cycle after address) and done flag
//
// Build option: define TINY_HOST_TIMEOUT_EN to bound the RUN state to
// RUN_TIMEOUT cycles; without it the block waits for the core indefinitely.
module tiny_host_if #(
   parameter int unsigned RUN_TIMEOUT = 1000000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_data,
   output logic         busy,
   output logic         err,
   output logic         core_reset,
   output logic         core_sel,
   output logic         core_w,
   output logic [5:0]   core_addr,
   output logic [197:0] core_data,
   input  logic [197:0] core_out,
   input  logic         core_done
);

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned VAL_W     = 198;
   localparam int unsigned ADDR_W    = 6;
   localparam int unsigned LAST_WORD = 6;
   localparam int unsigned TOP_W     = VAL_W - LAST_WORD * WORD_W;
   localparam int unsigned RES_W     = VAL_W - WORD_W;
   localparam int unsigned RES_BASE  = 9;
   localparam int unsigned RES_CNT   = 6;
   localparam int unsigned LAST_OP   = 3;

   typedef enum logic [2:0] {
      S_LOAD, S_WRITE, S_START, S_RUN, S_READ, S_CAPTURE, S_UNLOAD
   } state_t;

   state_t             state, state_nxt;
   logic [2:0]         word_cnt;
   logic [1:0]         op_cnt;
   logic [2:0]         res_idx;
   logic [VAL_W-1:0]   in_buf;
   logic [RES_W-1:0]   res_buf;
   logic               done_q;
   logic               in_fire, out_fire, done_edge, last_word, timeout;
   logic               in_ready_nxt, out_valid_nxt, busy_nxt, core_reset_nxt;
   logic               core_sel_nxt, core_w_nxt;
   logic [ADDR_W-1:0]  core_addr_nxt;

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign last_word = (word_cnt == 3'(LAST_WORD));
   // done_q follows core_done every cycle, so the value seen in START is the
   // reference for RUN: a core_done already high on entry is not an edge.
   assign done_edge = core_done && !done_q;
   assign core_data = in_buf;

   // Operand address map: xp, yp, xq, yq
   function automatic logic [ADDR_W-1:0] op_addr(input logic [1:0] idx);
      case (idx)
         2'd0:    op_addr = ADDR_W'(3);
         2'd1:    op_addr = ADDR_W'(5);
         2'd2:    op_addr = ADDR_W'(6);
         default: op_addr = ADDR_W'(7);
      endcase
   endfunction

`ifdef TINY_HOST_TIMEOUT_EN
   localparam int unsigned RUN_W = $clog2(RUN_TIMEOUT + 1);
   logic [RUN_W-1:0] run_cnt;

   // Fires on the RUN_TIMEOUT-th RUN cycle unless the core finishes that cycle
   assign timeout = (state == S_RUN) && !done_edge && (run_cnt == RUN_W'(RUN_TIMEOUT - 1));

   // RUN cycle counter and sticky error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_cnt <= '0;
         err     <= 1'b0;
      end else begin
         if (state == S_RUN) run_cnt <= run_cnt + RUN_W'(1);
         else                run_cnt <= '0;
         if (timeout) err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   // No run bound in this build; RUN_TIMEOUT has no effect and err stays 0
   assign err = 1'b0 & (RUN_TIMEOUT == 32'd0);
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_LOAD;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_LOAD:    if (in_fire && last_word) state_nxt = S_WRITE;
         S_WRITE:   state_nxt = (op_cnt == 2'(LAST_OP)) ? S_START : S_LOAD;
         S_START:   state_nxt = S_RUN;
         S_RUN:     if (done_edge)    state_nxt = S_READ;
                    else if (timeout) state_nxt = S_LOAD;
         S_READ:    state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = S_UNLOAD;
         S_UNLOAD:  if (out_fire && last_word)
                       state_nxt = (res_idx == 3'(RES_CNT)) ? S_LOAD : S_READ;
         default:   state_nxt = S_LOAD;
      endcase
   end

   // Output decode for the upcoming state; registered below
   always_comb begin
      in_ready_nxt   = 1'b0;
      out_valid_nxt  = 1'b0;
      core_reset_nxt = 1'b0;
      core_sel_nxt   = 1'b0;
      core_w_nxt     = 1'b0;
      core_addr_nxt  = '0;
      case (state_nxt)
         S_LOAD: begin
            in_ready_nxt   = 1'b1;
            core_reset_nxt = 1'b1;
         end
         S_WRITE: begin
            core_reset_nxt = 1'b1;
            core_sel_nxt   = 1'b1;
            core_w_nxt     = 1'b1;
            core_addr_nxt  = op_addr(op_cnt);
         end
         S_START:  core_reset_nxt = 1'b1;
         S_READ: begin
            core_sel_nxt  = 1'b1;
            core_addr_nxt = ADDR_W'(RES_BASE) + ADDR_W'(res_idx);
         end
         S_UNLOAD: out_valid_nxt = 1'b1;
         default:  ;
      endcase
      // Idle only when back in LOAD with no operand word held
      busy_nxt = (state_nxt != S_LOAD) || (state == S_WRITE) ||
                 ((state == S_LOAD) && (in_fire || word_cnt != 3'd0 || op_cnt != 2'd0));
   end

   // Output registers and datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         core_reset <= 1'b1;
         core_sel   <= 1'b0;
         core_w     <= 1'b0;
         core_addr  <= '0;
         out_data   <= '0;
         in_buf     <= '0;
         res_buf    <= '0;
         word_cnt   <= '0;
         op_cnt     <= '0;
         res_idx    <= '0;
         done_q     <= 1'b0;
      end else begin
         in_ready   <= in_ready_nxt;
         out_valid  <= out_valid_nxt;
         busy       <= busy_nxt;
         core_reset <= core_reset_nxt;
         core_sel   <= core_sel_nxt;
         core_w     <= core_w_nxt;
         core_addr  <= core_addr_nxt;
         done_q     <= core_done;
         case (state)
            S_LOAD: if (in_fire) begin
               for (int k = 0; k < int'(LAST_WORD); k++)
                  if (word_cnt == 3'(k)) in_buf[k*WORD_W +: WORD_W] <= in_data;
               // Last word carries only the top bits; the rest is ignored
               if (last_word) in_buf[VAL_W-1 -: TOP_W] <= in_data[TOP_W-1:0];
               word_cnt <= last_word ? 3'd0 : word_cnt + 3'd1;
            end
            S_WRITE: op_cnt <= op_cnt + 2'd1;
            S_CAPTURE: begin
               out_data <= core_out[WORD_W-1:0];
               res_buf  <= core_out[VAL_W-1:WORD_W];
               res_idx  <= res_idx + 3'd1;
            end
            S_UNLOAD: if (out_fire) begin
               // Shift-out leaves zeros above the 6 top bits in the last word
               out_data <= res_buf[WORD_W-1:0];
               res_buf  <= res_buf >> WORD_W;
               word_cnt <= last_word ? 3'd0 : word_cnt + 3'd1;
               if (last_word && res_idx == 3'(RES_CNT)) res_idx <= 3'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tiny_host_if.sv
// Bench for tiny_host_if with a mock core: operand words are driven by tasks,
// expected RAM writes and result words are queued, and a negedge monitor
// compares everything the block presents against those queues.
module tb_tiny_host_if;

   localparam logic [197:0] XP = 198'h288162298554054820552a05426081a1842886a58916a6249;
   localparam logic [197:0] YP = 198'h2895955069089214054596a189a4420556589054140941695;
   localparam logic [197:0] R0 = 198'h0580908654985206a92415296589411858a9211984160a180;
   localparam logic [197:0] R5 = 198'h2a88582860a80605825150584a8a8099491029242961a5685;

   typedef struct packed {
      logic [5:0]   addr;
      logic [197:0] data;
   } wr_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [31:0]  out_data;
   logic         busy, err, core_reset, core_sel, core_w;
   logic [5:0]   core_addr;
   logic [197:0] core_data;
   logic [197:0] core_out = '0;
   logic         core_done = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   wr_t          wq[$];
   logic [31:0]  oq[$];
   logic [197:0] res_mem [0:5];
   int  n_words = 0, n_writes = 0;
   bit  toggle_rdy = 0, mock_pre = 0, mock_never = 0;
   int  mock_delay = 10;
   int  mcyc = 0;

   tiny_host_if #(.RUN_TIMEOUT(100)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .err(err), .core_reset(core_reset),
      .core_sel(core_sel), .core_w(core_w), .core_addr(core_addr), .core_data(core_data),
      .core_out(core_out), .core_done(core_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [197:0] act, input logic [197:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got event want none", name);
   endtask

   // Mock core: result RAM at 9..14, done raised mock_delay cycles into the run
   always @(posedge clk) begin
      core_out <= (core_addr >= 6'd9 && core_addr <= 6'd14) ? res_mem[core_addr - 6'd9] : '0;
      if (core_reset) begin
         mcyc      <= 0;
         core_done <= mock_pre;
      end else begin
         mcyc <= mcyc + 1;
         if (mock_never)                core_done <= 1'b0;
         else if (mcyc == mock_delay)   core_done <= 1'b1;
         else if (mock_pre && mcyc == 1) core_done <= 1'b0;
      end
   end

   // Result-side ready: constant high or alternating every cycle
   initial forever begin
      @(posedge clk);
      #2;
      out_ready = toggle_rdy ? !out_ready : 1'b1;
   end

   // Monitor / scoreboard
   int acc_cnt = 0, t_last = 0, d_rise = 0;
   bit first_ov = 0;
   logic prev_cr = 1'b1, prev_done = 1'b0, prev_ov = 1'b0, prev_ordy = 1'b0;
   logic [31:0] prev_od = '0;
   always @(negedge clk) begin
      if (!reset) begin
         acc_cnt = 0; first_ov = 0; prev_cr = 1'b1; prev_done = 1'b0; prev_ov = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            acc_cnt++;
            if (acc_cnt == 28) begin t_last = cyc; acc_cnt = 0; end
         end
         if (prev_cr && !core_reset) begin
            check("load_to_run_latency", 198'(cyc - t_last), 198'd3);
            first_ov = 1; d_rise = -1000;
         end
         if (!core_reset && core_done && !prev_done) d_rise = cyc;
         if (out_valid && !prev_ov && first_ov) begin
            check("done_to_out_latency", 198'(cyc - d_rise), 198'd3);
            first_ov = 0;
         end
         if (core_w) begin
            n_writes++;
            if (wq.size() == 0) fail("unexpected_write");
            else begin
               wr_t e;
               e = wq.pop_front();
               check("write_addr", 198'(core_addr), 198'(e.addr));
               check("write_data", core_data, e.data);
               check("write_sel", 198'(core_sel), 198'd1);
            end
         end
         if (out_valid) begin
            if (prev_ov && !prev_ordy) check("out_hold", 198'(out_data), 198'(prev_od));
            if (out_ready) begin
               n_words++;
               if (oq.size() == 0) fail("unexpected_out_word");
               else check("out_word", 198'(out_data), 198'(oq.pop_front()));
            end
         end
         prev_cr = core_reset; prev_done = core_done; prev_ov = out_valid;
         prev_ordy = out_ready; prev_od = out_data;
      end
   end

   // Called at posedge+2; returns at posedge+2 right after the word is taken
   task automatic send_word(input logic [31:0] w);
      int n;
      logic acc;
      n = 0; acc = 1'b0;
      in_valid = 1'b1; in_data = w;
      while (!acc && n < 500) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #2;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) fail("in_ready_timeout");
   endtask

   task automatic send_operand(input logic [197:0] v, input bit junk);
      logic [31:0] w;
      for (int k = 0; k < 6; k++) send_word(v[k*32 +: 32]);
      w = {junk ? 26'h3ffffff : 26'h0, v[197:192]};
      send_word(w);
   endtask

   task automatic push_results();
      logic [197:0] r;
      for (int j = 0; j < 6; j++) begin
         r = res_mem[j];
         for (int k = 0; k < 6; k++) oq.push_back(r[k*32 +: 32]);
         oq.push_back({26'h0, r[197:192]});
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (oq.size() != 0 && n < 3000) begin @(negedge clk); n++; end
      if (n == 3000) fail("drain_timeout");
      @(negedge clk);
      check("idle_busy", 198'(busy), 198'd0);
      check("idle_in_ready", 198'(in_ready), 198'd1);
      check("idle_core_reset", 198'(core_reset), 198'd1);
   endtask

   task automatic run(input logic [197:0] a, b, c, d, input bit junk);
      @(posedge clk);
      #2;
      push_results();
      wq.push_back('{6'd3, a}); wq.push_back('{6'd5, b});
      wq.push_back('{6'd6, c}); wq.push_back('{6'd7, d});
      send_operand(a, junk); send_operand(b, junk);
      send_operand(c, junk); send_operand(d, junk);
      wait_idle();
   endtask

   // Asserted at posedge+2; checks the reset values and releases at posedge+2
   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk);
      #2;
      check("rst_in_ready", 198'(in_ready), 198'd1);
      check("rst_out_valid", 198'(out_valid), 198'd0);
      check("rst_busy", 198'(busy), 198'd0);
      check("rst_err", 198'(err), 198'd0);
      check("rst_core_reset", 198'(core_reset), 198'd1);
      check("rst_core_sel", 198'(core_sel), 198'd0);
      check("rst_core_w", 198'(core_w), 198'd0);
      check("rst_core_addr", 198'(core_addr), 198'd0);
      check("rst_core_data", core_data, 198'd0);
      check("rst_out_data", 198'(out_data), 198'd0);
      reset = 1'b1;
   endtask

   initial begin
      do_reset();

      // Reference operands, result 0 and 5 from the real-core vector
      res_mem[0] = R0; res_mem[1] = 198'h1; res_mem[2] = {99{2'b10}};
      res_mem[3] = {66{3'b011}}; res_mem[4] = {1'b1, 197'h0}; res_mem[5] = R5;
      run(XP, YP, XP, YP, 1'b0);

      // Stalling consumer, junk in upper bits of the top operand word
      toggle_rdy = 1;
      res_mem[0] = {198{1'b1}}; res_mem[1] = '0; res_mem[2] = R5;
      res_mem[3] = R0; res_mem[4] = {99{2'b01}}; res_mem[5] = {198{1'b1}};
      run({198{1'b1}}, {99{2'b01}}, 198'h0, {6'h2a, 192'h0}, 1'b1);
      toggle_rdy = 0;

      // core_done already high when the run starts
      mock_pre = 1; mock_delay = 8;
      run(YP, XP, {99{2'b10}}, 198'h123456789, 1'b0);
      mock_pre = 0; mock_delay = 10;

      // Reset after 15 operand words, then a clean run
      @(posedge clk);
      #2;
      wq.push_back('{6'd3, XP}); wq.push_back('{6'd5, YP});
      send_operand(XP, 1'b0); send_operand(YP, 1'b0); send_word(32'hdead_beef);
      check("mid_load_busy", 198'(busy), 198'd1);
      do_reset();
      run(XP, YP, XP, YP, 1'b0);

`ifdef TINY_HOST_TIMEOUT_EN
      begin
         int n;
         mock_never = 1;
         @(posedge clk);
         #2;
         wq.push_back('{6'd3, XP}); wq.push_back('{6'd5, YP});
         wq.push_back('{6'd6, XP}); wq.push_back('{6'd7, YP});
         send_operand(XP, 1'b0); send_operand(YP, 1'b0);
         send_operand(XP, 1'b0); send_operand(YP, 1'b0);
         n = 0;
         while (core_reset && n < 50) begin @(negedge clk); n++; end
         n = 0;
         while (!core_reset && n < 500) begin
            @(negedge clk);
            n++;
            if (!core_reset) check("run_err_low", 198'(err), 198'd0);
         end
         check("run_cycles", 198'(n - 1), 198'd100);
         check("timeout_err", 198'(err), 198'd1);
         check("timeout_in_ready", 198'(in_ready), 198'd1);
         check("timeout_out_valid", 198'(out_valid), 198'd0);
         mock_never = 0;
      end
      check("total_writes", 198'(n_writes), 198'd22);
`else
      check("total_writes", 198'(n_writes), 198'd18);
`endif
      check("total_words", 198'(n_words), 198'd168);
      check("write_queue_empty", 198'(wq.size()), 198'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tiny_host_if.md
TINY_HOST_IF -- requirements
Module: tiny_host_if

Interface
REQ-001 Parameter RUN_TIMEOUT, default 1000000, max core run cycles before timeout (used only with TINY_HOST_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid / in_ready / in_data  input / output / input  1/1/32  host operand word stream; transfer when both high.
REQ-005 out_valid / out_ready / out_data  output / input / output  1/1/32  result word stream; transfer when both high.
REQ-006 busy  output  1  high from first accepted operand word until last result word transferred.
REQ-007 err  output  1  sticky run-timeout flag; constant 0 when TINY_HOST_TIMEOUT_EN is undefined.
REQ-008 core_reset  output  1  active-high hold to the pairing core; high keeps core FSM silent.
REQ-009 core_sel / core_w / core_addr / core_data  output  1/1/6/198  core RAM access port.
REQ-010 core_out / core_done  input  198/1  core read data (valid one cycle after core_addr applied) and completion flag.

Function
REQ-011 Operand format: 198-bit value sent as 7 words, word 0 = bits [31:0], word 6 bits [5:0] = bits [197:192]; word 6 bits [31:6] ignored.
REQ-012 Load order: 4 operands written to core addresses 3, 5, 6, 7 (xp, yp, xq, yq), 28 words total.
REQ-013 States: LOAD, WRITE, START, RUN, READ, CAPTURE, UNLOAD.
REQ-014 LOAD: in_ready=1, core_reset=1, core_sel=0; shift in words; 7th accepted word -> WRITE next cycle.
REQ-015 WRITE: exactly one cycle, core_sel=1, core_w=1, core_addr=operand address, core_data=assembled value, in_ready=0; -> LOAD if operands remain, else START.
REQ-016 START: one cycle, core_reset=1, core_sel=0; snapshot core_done into done-edge register; -> RUN.
REQ-017 RUN: core_reset=0, core_sel=0; -> READ on first rising edge of core_done (0 then 1 on consecutive cycles); stale high core_done on entry does not count.
REQ-018 READ: one cycle, core_sel=1, core_w=0, core_addr=9+j (j=0..5); -> CAPTURE.
REQ-019 CAPTURE: register core_out into 198-bit result buffer; -> UNLOAD.
REQ-020 UNLOAD: out_valid=1, emit buffer as 7 words (same packing as REQ-011, word 6 bits [31:6]=0); out_data held stable while out_valid=1 and out_ready=0; after 7th transfer -> READ (j+1) or, after j=5, LOAD with core_reset=1 asserted the same cycle.
REQ-021 Results emitted in address order 9..14, 42 words per run; in_ready=0 in every state except LOAD.
REQ-022 Latency: last operand word accepted at cycle t -> core_reset low at t+3; core_done rise at cycle d -> first out_valid at d+3.
REQ-023 core_w never high outside WRITE; core_sel low in LOAD, START, RUN, CAPTURE, UNLOAD.

Reset
REQ-024 reset low (any state, including mid-write or mid-unload): state=LOAD, word/operand/result counters=0, in_ready=1, out_valid=0, busy=0, err=0, core_reset=1, core_sel=0, core_w=0, core_addr=0, core_data=0, out_data=0; partial operands discarded.

Configuration
REQ-025 With TINY_HOST_TIMEOUT_EN defined: RUN counts cycles; at RUN_TIMEOUT without done edge, err=1 (sticky until reset), -> LOAD with core_reset=1, no results emitted.
REQ-026 Without TINY_HOST_TIMEOUT_EN: no counter, RUN waits indefinitely, err tied 0.

Verification
REQ-027 Real core; load xp=xq=194'h288162298554054820552a05426081a1842886a58916a6249, yp=yq=194'h2895955069089214054596a189a4420556589054140941695 -> result 0 = 194'h0580908654985206a92415296589411858a9211984160a180, result 5 = 194'h2a88582860a80605825150584a8a8099491029242961a5685.
REQ-028 Mock core, out_ready toggling 1/0 each cycle -> 42 words, each stable while stalled, none lost or duplicated.
REQ-029 Mock core holds core_done=1 before START -> block stays in RUN until done falls and rises again.
REQ-030 reset pulse after 15 operand words -> all outputs at REQ-024 values; fresh 28-word load completes normally.
REQ-031 TINY_HOST_TIMEOUT_EN, RUN_TIMEOUT=100, core_done never rises -> err=1 on cycle 100 of RUN, out_valid stays 0, in_ready=1 next cycle.
REQ-032 Write-cycle check: core_w high exactly 4 cycles per run, at addresses 3, 5, 6, 7, in that order.
